// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic [3:0] MEM_NOP = 4'h0;
  localparam logic [3:0] MEM_LB  = 4'h1;
  localparam logic [3:0] MEM_LH  = 4'h2;
  localparam logic [3:0] MEM_LW  = 4'h3;
  localparam logic [3:0] MEM_LBU = 4'h4;
  localparam logic [3:0] MEM_LHU = 4'h5;
  localparam logic [3:0] MEM_SB  = 4'h6;
  localparam logic [3:0] MEM_SH  = 4'h7;
  localparam logic [3:0] MEM_SW  = 4'h8;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_DM = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-bus signals; names follow the arbiter's view
// (slave = arbiter, master = requesters plus bus).
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_ack_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  if_stall_o;

  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [ADDR_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0] dm_wdata_i;
  logic [3:0]            dm_op_i;
  logic                  dm_ack_o;
  logic [DATA_WIDTH-1:0] dm_rdata_o;
  logic                  dm_err_o;
  logic                  dm_stall_o;

  logic                  bus_req_o;
  logic                  bus_we_o;
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic [DATA_WIDTH-1:0] bus_wdata_o;
  logic [3:0]            bus_op_o;
  logic                  bus_ack_i;
  logic [DATA_WIDTH-1:0] bus_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_ack_o, if_rdata_o, if_stall_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_op_i,
    output dm_ack_o, dm_rdata_o, dm_err_o, dm_stall_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_op_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_ack_o, if_rdata_o, if_stall_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_op_i,
    input  dm_ack_o, dm_rdata_o, dm_err_o, dm_stall_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_op_o,
    output bus_ack_i, bus_rdata_i
  );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Bus wait counter: cleared outside an access, counts while enabled and
// flags the last permitted wait cycle.
module mem_arb_timer #(
  parameter int LIMIT = 16,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_s;

  assign last_s    = (cnt_q == CNT_W'(LIMIT - 1));
  assign timeout_o = en_i & last_s;

  // Next count: holds at the last cycle so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !last_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the
// load/store port: IDLE -> BUSY_IF|BUSY_DM -> RESP -> IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 16
) (
  input logic                clk_i,
  input logic                rst_n_i,
  mem_port_arbiter_if.slave  p
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]            bus_op_q, bus_op_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  if_ack_q, if_ack_d;
  logic                  dm_ack_q, dm_ack_d;
  logic                  busy_s;
  logic                  timeout_s;
  logic                  grant_dm_s;

  assign busy_s = (state_q == ARB_BUSY_IF) || (state_q == ARB_BUSY_DM);
  // DM normally wins; a starved fetch takes the bus once the limit is hit.
  assign grant_dm_s = p.dm_req_i &&
                      !(p.if_req_i && (starve_q == STARVE_W'(STARVE_LIMIT)));

  mem_arb_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (!busy_s),
    .en_i      (busy_s),
    .timeout_o (timeout_s)
  );

  // Next-state, grant and bus-field logic.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_op_d    = bus_op_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_dm_s) begin
          state_d     = ARB_BUSY_DM;
          bus_req_d   = 1'b1;
          bus_we_d    = p.dm_we_i;
          bus_addr_d  = p.dm_addr_i;
          bus_wdata_d = p.dm_wdata_i;
          bus_op_d    = p.dm_op_i;
          if (p.if_req_i && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
          end else begin
            starve_d = starve_q;
          end
        end else if (p.if_req_i) begin
          state_d     = ARB_BUSY_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = p.if_addr_i;
          bus_wdata_d = '0;
          bus_op_d    = MEM_LW;
          starve_d    = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_DM: begin
        if (p.bus_ack_i || timeout_s) begin
          state_d   = ARB_RESP;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_op_d  = MEM_NOP;
          err_d     = !p.bus_ack_i;
          rdata_d   = (p.bus_ack_i && !bus_we_q) ? p.bus_rdata_i : '0;
          if_ack_d  = (state_q == ARB_BUSY_IF);
          dm_ack_d  = (state_q == ARB_BUSY_DM);
        end else begin
          state_d = state_q;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: begin
        state_d   = ARB_IDLE;
        bus_req_d = 1'b0;
        bus_op_d  = MEM_NOP;
        err_d     = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ARB_IDLE;
      starve_q    <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_op_q    <= MEM_NOP;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_op_q    <= bus_op_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  assign p.if_ack_o    = if_ack_q;
  assign p.if_rdata_o  = rdata_q;
  assign p.if_stall_o  = p.if_req_i & ~if_ack_q;
  assign p.dm_ack_o    = dm_ack_q;
  assign p.dm_rdata_o  = rdata_q;
  assign p.dm_err_o    = err_q;
  assign p.dm_stall_o  = p.dm_req_i & ~dm_ack_q;
  assign p.bus_req_o   = bus_req_q;
  assign p.bus_we_o    = bus_we_q;
  assign p.bus_addr_o  = bus_addr_q;
  assign p.bus_wdata_o = bus_wdata_q;
  assign p.bus_op_o    = bus_op_q;

endmodule
